rr_multi_select_arbiter: RTL and testbench

//  Parametrised successor to the single-grant priority encoder. Each cycle it

---
 rtl/rr_multi_select_arbiter.sv | 135 +++++++++++++
 tb/tb_rr_multi_select_arbiter.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/rr_multi_select_arbiter.sv
//==============================================================================
// Module      : rr_multi_select_arbiter
// Description : Multi-grant select logic. Picks up to GRANTS of WIDTH requesters
//               per cycle in fixed-priority or round-robin order, behind a
//               registered valid/ready output stage.
// Revision    : 1.0 - initial release
//==============================================================================
`timescale 1ns/1ps
`default_nettype none

module rr_multi_select_arbiter #(
    parameter int WIDTH   = 8,
    parameter int GRANTS  = 2,
    parameter int RR_MODE = 1,
    localparam int IDX_W  = (WIDTH > 1) ? $clog2(WIDTH) : 1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [WIDTH-1:0]        req,
    input  logic                    out_ready,
    output logic                    out_valid,
    output logic [GRANTS-1:0]       gnt_valid,
    output logic [GRANTS*IDX_W-1:0] gnt_idx,
    output logic [WIDTH-1:0]        gnt_vec,
    output logic [IDX_W-1:0]        rr_ptr
);

    localparam logic [IDX_W:0]   c_width    = (IDX_W+1)'(WIDTH);
    localparam logic [IDX_W-1:0] c_last_idx = IDX_W'(WIDTH - 1);

    logic                    r_out_valid;
    logic [GRANTS-1:0]       r_gnt_valid;
    logic [GRANTS*IDX_W-1:0] r_gnt_idx;
    logic [WIDTH-1:0]        r_gnt_vec;
    logic [IDX_W-1:0]        r_rr_ptr;

    logic                    w_accept;
    logic                    w_load;
    logic [WIDTH-1:0]        w_eff_req;
    logic [IDX_W-1:0]        w_start;
    logic [IDX_W:0]          w_sum;
    logic [IDX_W-1:0]        w_pos [WIDTH];
    logic [WIDTH-1:0]        w_rot;
    int                      w_seen;
    logic [GRANTS-1:0]       w_sel_valid;
    logic [GRANTS*IDX_W-1:0] w_sel_idx;
    logic [WIDTH-1:0]        w_sel_vec;
    logic [IDX_W-1:0]        w_last_idx;
    logic [IDX_W-1:0]        w_next_ptr;

    assign w_accept = r_out_valid & out_ready;
    assign w_load   = ~r_out_valid | out_ready;

    // Lines leaving this cycle are masked so a requester that drops req one
    // cycle late cannot be granted twice.
    assign w_eff_req = req & ~(w_accept ? r_gnt_vec : '0) & {WIDTH{~rst}};
    assign w_start   = (RR_MODE != 0) ? r_rr_ptr : '0;

    // Rotate the request vector so scan position 0 is the start index.
    always_comb begin
        w_sum = '0;
        w_rot = '0;
        for (int o = 0; o < WIDTH; o++) begin
            w_sum = {1'b0, w_start} + (IDX_W+1)'(o);
            if (w_sum >= c_width) begin
                w_sum = w_sum - c_width;
            end
            w_pos[o] = w_sum[IDX_W-1:0];
            w_rot[o] = w_eff_req[w_pos[o]];
        end
    end

    // Slot k takes the (k+1)-th set bit of the rotated vector, so valid
    // slots are naturally packed from slot 0.
    always_comb begin
        w_seen      = 0;
        w_sel_valid = '0;
        w_sel_idx   = '0;
        w_sel_vec   = '0;
        w_last_idx  = '0;
        for (int k = 0; k < GRANTS; k++) begin
            w_seen = 0;
            for (int o = 0; o < WIDTH; o++) begin
                if (w_rot[o]) begin
                    if (w_seen == k) begin
                        w_sel_valid[k]                = 1'b1;
                        w_sel_idx[k*IDX_W +: IDX_W]   = w_pos[o];
                        w_sel_vec[w_pos[o]]           = 1'b1;
                        w_last_idx                    = w_pos[o];
                    end
                    w_seen = w_seen + 1;
                end
            end
        end
    end

    assign w_next_ptr = (w_last_idx == c_last_idx) ? '0 : w_last_idx + IDX_W'(1);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_out_valid <= 1'b0;
            r_gnt_valid <= '0;
            r_gnt_idx   <= '0;
            r_gnt_vec   <= '0;
            r_rr_ptr    <= '0;
        end else if (w_load) begin
            r_out_valid <= |w_sel_valid;
            r_gnt_valid <= w_sel_valid;
            r_gnt_idx   <= w_sel_idx;
            r_gnt_vec   <= w_sel_vec;
            if ((RR_MODE != 0) && (|w_sel_valid)) begin
                r_rr_ptr <= w_next_ptr;
            end
        end
    end

    assign out_valid = r_out_valid;
    assign gnt_valid = r_gnt_valid;
    assign gnt_idx   = r_gnt_idx;
    assign gnt_vec   = r_gnt_vec;
    assign rr_ptr    = r_rr_ptr;

    // Structural invariants of the registered grant set.
    a_popcount : assert property (@(posedge clk) disable iff (rst)
        $countones(gnt_vec) == $countones(gnt_valid));

    a_packed : assert property (@(posedge clk) disable iff (rst)
        (gnt_valid & (gnt_valid + GRANTS'(1))) == '0);

    a_stall_hold : assert property (@(posedge clk) disable iff (rst)
        (out_valid && !out_ready) |=> ($stable(gnt_vec) && $stable(rr_ptr)));

endmodule

`default_nettype wire

// File: tb/tb_rr_multi_select_arbiter.sv
//==============================================================================
// Module      : tb_rr_multi_select_arbiter
// Description : Directed and constrained-random checks for the multi-select
//               arbiter in round-robin (8x2, 5x3) and fixed-priority modes.
// Revision    : 1.0 - initial release
//==============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_rr_multi_select_arbiter;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // 8x2 round-robin instance
    logic [7:0] req_a;
    logic       ready_a, ov_a;
    logic [1:0] gv_a;
    logic [5:0] gi_a;
    logic [7:0] vec_a;
    logic [2:0] ptr_a;

    // 8x2 fixed-priority instance
    logic [7:0] req_b;
    logic       ready_b, ov_b;
    logic [1:0] gv_b;
    logic [5:0] gi_b;
    logic [7:0] vec_b;
    logic [2:0] ptr_b;

    // 5x3 round-robin instance
    logic [4:0] req_c;
    logic       ready_c, ov_c;
    logic [2:0] gv_c;
    logic [8:0] gi_c;
    logic [4:0] vec_c;
    logic [2:0] ptr_c;

    rr_multi_select_arbiter #(.WIDTH(8), .GRANTS(2), .RR_MODE(1)) u_dut_a (
        .clk(clk), .rst(rst), .req(req_a), .out_ready(ready_a), .out_valid(ov_a),
        .gnt_valid(gv_a), .gnt_idx(gi_a), .gnt_vec(vec_a), .rr_ptr(ptr_a));

    rr_multi_select_arbiter #(.WIDTH(8), .GRANTS(2), .RR_MODE(0)) u_dut_b (
        .clk(clk), .rst(rst), .req(req_b), .out_ready(ready_b), .out_valid(ov_b),
        .gnt_valid(gv_b), .gnt_idx(gi_b), .gnt_vec(vec_b), .rr_ptr(ptr_b));

    rr_multi_select_arbiter #(.WIDTH(5), .GRANTS(3), .RR_MODE(1)) u_dut_c (
        .clk(clk), .rst(rst), .req(req_c), .out_ready(ready_c), .out_valid(ov_c),
        .gnt_valid(gv_c), .gnt_idx(gi_c), .gnt_vec(vec_c), .rr_ptr(ptr_c));

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // Compares a full 8x2 grant set; slot indices only matter where valid.
    task automatic chk_set(input string tag,
                           input logic ov, input logic [1:0] gv, input logic [5:0] gi,
                           input logic [7:0] vec, input logic [2:0] ptr,
                           input logic [1:0] egv, input logic [5:0] egi,
                           input logic [7:0] evec, input logic [2:0] eptr);
        logic [5:0] m;
        m = {{3{egv[1]}}, {3{egv[0]}}};
        chk({tag, ".out_valid"}, ov, |egv);
        chk({tag, ".gnt_valid"}, gv, egv);
        chk({tag, ".gnt_idx"}, gi & m, egi & m);
        chk({tag, ".gnt_vec"}, vec, evec);
        chk({tag, ".rr_ptr"}, ptr, eptr);
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    logic [2:0] lo, hi;
    logic [4:0] pend;
    int         waitc [5];
    logic       p_ov, p_ready, ld, acc;
    logic [2:0] p_gv, p_ptr, pk, lst, eptr;
    logic [8:0] p_gi;
    logic [4:0] p_vec, p_req, oh;

    initial begin
        rst = 1'b1;
        req_a = 8'hFF; ready_a = 1'b1;
        req_b = 8'h00; ready_b = 1'b0;
        req_c = 5'h00; ready_c = 1'b0;
        tick;
        tick;
        chk_set("reset", ov_a, gv_a, gi_a, vec_a, ptr_a, 2'b00, 6'h00, 8'h00, 3'd0);

        rst = 1'b0;
        tick;
        chk_set("first", ov_a, gv_a, gi_a, vec_a, ptr_a, 2'b11, {3'd1, 3'd0}, 8'h03, 3'd2);

        // Full request held: pairs rotate around the ring.
        for (int i = 0; i < 4; i++) begin
            tick;
            lo = 3'(2*i + 2);
            hi = lo + 3'd1;
            chk_set($sformatf("rr%0d", i), ov_a, gv_a, gi_a, vec_a, ptr_a,
                    2'b11, {hi, lo}, 8'h03 << lo, lo + 3'd2);
        end

        tick;
        tick;
        chk("pre_wrap.rr_ptr", ptr_a, 3'd6);
        req_a = 8'h82;
        tick;
        chk_set("wrap", ov_a, gv_a, gi_a, vec_a, ptr_a, 2'b11, {3'd1, 3'd7}, 8'h82, 3'd2);

        ready_a = 1'b0;
        req_a = 8'hFF;
        tick;
        chk_set("stall0", ov_a, gv_a, gi_a, vec_a, ptr_a, 2'b11, {3'd1, 3'd7}, 8'h82, 3'd2);
        req_a = 8'h0F;
        tick;
        chk_set("stall1", ov_a, gv_a, gi_a, vec_a, ptr_a, 2'b11, {3'd1, 3'd7}, 8'h82, 3'd2);
        req_a = 8'h30;
        tick;
        chk_set("stall2", ov_a, gv_a, gi_a, vec_a, ptr_a, 2'b11, {3'd1, 3'd7}, 8'h82, 3'd2);

        // Lines 7 and 1 still request but were just accepted: only line 0 wins.
        ready_a = 1'b1;
        req_a = 8'h83;
        tick;
        chk_set("post_stall", ov_a, gv_a, gi_a, vec_a, ptr_a, 2'b01, {3'd0, 3'd0}, 8'h01, 3'd1);

        req_a = 8'h00;
        tick;
        chk_set("idle", ov_a, gv_a, gi_a, vec_a, ptr_a, 2'b00, 6'h00, 8'h00, 3'd1);

        req_a = 8'hFF;
        tick;
        chk_set("after_idle", ov_a, gv_a, gi_a, vec_a, ptr_a, 2'b11, {3'd2, 3'd1}, 8'h06, 3'd3);

        ready_a = 1'b0;
        tick;
        chk_set("hold", ov_a, gv_a, gi_a, vec_a, ptr_a, 2'b11, {3'd2, 3'd1}, 8'h06, 3'd3);
        #2 rst = 1'b1;
        #1;
        chk_set("rst_mid", ov_a, gv_a, gi_a, vec_a, ptr_a, 2'b00, 6'h00, 8'h00, 3'd0);
        req_a = 8'h00;
        @(posedge clk);
        #1 rst = 1'b0;
        tick;
        chk_set("post_rst", ov_a, gv_a, gi_a, vec_a, ptr_a, 2'b00, 6'h00, 8'h00, 3'd0);

        // Fixed priority: accepted lines are masked on the accept cycle,
        // so a steady request alternates between a grant and an empty set.
        ready_b = 1'b1;
        req_b = 8'h0A;
        tick;
        chk_set("fx0", ov_b, gv_b, gi_b, vec_b, ptr_b, 2'b11, {3'd3, 3'd1}, 8'h0A, 3'd0);
        tick;
        chk_set("fx1", ov_b, gv_b, gi_b, vec_b, ptr_b, 2'b00, 6'h00, 8'h00, 3'd0);
        tick;
        chk_set("fx2", ov_b, gv_b, gi_b, vec_b, ptr_b, 2'b11, {3'd3, 3'd1}, 8'h0A, 3'd0);
        req_b = 8'h08;
        tick;
        chk_set("fx3", ov_b, gv_b, gi_b, vec_b, ptr_b, 2'b00, 6'h00, 8'h00, 3'd0);
        tick;
        chk_set("fx_single", ov_b, gv_b, gi_b, vec_b, ptr_b, 2'b01, {3'd0, 3'd3}, 8'h08, 3'd0);

        // Random stress on 5x3: requests stay up until their grant is accepted.
        pend = '0;
        for (int l = 0; l < 5; l++) waitc[l] = 0;
        for (int cyc = 0; cyc < 400; cyc++) begin
            pend    = pend | (5'($urandom) & 5'($urandom));
            req_c   = pend;
            ready_c = ($urandom_range(0, 3) != 0);
            p_ov = ov_c; p_gv = gv_c; p_gi = gi_c; p_vec = vec_c; p_ptr = ptr_c;
            p_req = req_c; p_ready = ready_c;
            tick;
            ld  = !p_ov || p_ready;
            acc = p_ov && p_ready;

            chk("c.out_valid", ov_c, |gv_c);
            pk = gv_c & (gv_c + 3'd1);
            chk("c.packed", pk, 3'd0);
            oh  = '0;
            lst = '0;
            for (int k = 0; k < 3; k++) begin
                if (gv_c[k]) begin
                    oh  = oh | (5'd1 << gi_c[k*3 +: 3]);
                    lst = gi_c[k*3 +: 3];
                end
            end
            chk("c.vec_vs_idx", vec_c, oh);
            chk("c.popcount", $countones(vec_c), $countones(gv_c));
            if (ld) begin
                chk("c.subset", vec_c & ~(p_req & ~(acc ? p_vec : 5'd0)), 5'd0);
                eptr = (|gv_c) ? ((lst == 3'd4) ? 3'd0 : lst + 3'd1) : p_ptr;
                chk("c.rr_ptr", ptr_c, eptr);
            end else begin
                chk("c.hold", {ov_c, gv_c, gi_c, vec_c, ptr_c},
                              {p_ov, p_gv, p_gi, p_vec, p_ptr});
            end

            if (acc) begin
                for (int l = 0; l < 5; l++) begin
                    if (p_vec[l]) begin
                        waitc[l] = 0;
                        pend[l]  = 1'b0;
                    end else if (p_req[l]) begin
                        waitc[l] = waitc[l] + 1;
                        chk($sformatf("c.wait%0d_le3", l), waitc[l] <= 3, 1'b1);
                    end
                end
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
